// File: rtl/nn_acc_host_master.sv
// Avalon-MM-style host master: streams weights then image words into the MAC accelerator,
// polls its ready status and returns the result. Optional poll timeout: NN_HOST_MASTER_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for start
// LOAD_W    | writing weight words from the upstream stream
// LOAD_I    | writing image words; holds one cycle after the last word
// POLL_REQ  | status read strobe on the bus
// POLL_WAIT | status read data returned, ready bit sampled
// RD_REQ    | result read strobe on the bus
// RD_WAIT   | result data returned and captured
module nn_acc_host_master #(
    parameter int         WEIGHT_COUNT = 96,
    parameter int         IMAGE_COUNT  = 96,
    parameter logic [7:0] WEIGHT_BASE  = 8'h01,
    parameter logic [7:0] IMAGE_BASE   = 8'h61,
    parameter logic [7:0] RESULT_ADDR  = 8'hC1,
    parameter logic [7:0] STATUS_ADDR  = 8'hD9,
    parameter int         POLL_LIMIT   = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        error,
    output logic [7:0]  address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    localparam int MAX_COUNT = (WEIGHT_COUNT > IMAGE_COUNT) ? WEIGHT_COUNT : IMAGE_COUNT;
    localparam int CW        = $clog2(MAX_COUNT + 1);
    localparam logic [CW-1:0] W_LAST = CW'(WEIGHT_COUNT - 1);
    localparam logic [CW-1:0] I_DONE = CW'(IMAGE_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_I,
        POLL_REQ,
        POLL_WAIT,
        RD_REQ,
        RD_WAIT
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    logic          accept;
    logic          handshake;
    logic          poll_timeout;

    // A start coinciding with the result pulse belongs to the finished inference and is dropped.
    assign accept    = (state == IDLE) && start && !result_valid;
    assign in_ready  = (state == LOAD_W) || ((state == LOAD_I) && (count != I_DONE));
    assign handshake = in_valid && in_ready;
    assign busy      = (state != IDLE);

    if (POLL_LIMIT < 1) begin : g_poll_limit_invalid
    end

`ifdef NN_HOST_MASTER_TIMEOUT_EN
    localparam int PCW = $clog2(POLL_LIMIT + 1);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);

    logic [PCW-1:0] poll_count;
    logic           error_q;

    assign poll_timeout = (state == POLL_WAIT) && !readdata[0] && (poll_count == POLL_LAST);
    assign error        = error_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_count <= '0;
            error_q    <= 1'b0;
        end else begin
            error_q <= poll_timeout;
            if (accept) begin
                poll_count <= '0;
            end else if ((state == POLL_WAIT) && !readdata[0]) begin
                poll_count <= poll_count + 1'b1;
            end
        end
    end
`else
    assign poll_timeout = 1'b0;
    assign error        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LOAD_W;
                    count_next = '0;
                end
            end
            LOAD_W: begin
                if (handshake) begin
                    if (count == W_LAST) begin
                        count_next = '0;
                        state_next = LOAD_I;
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
            end
            LOAD_I: begin
                // Leave one cycle after the last word so its write and the first read never overlap.
                if (count == I_DONE) begin
                    state_next = POLL_REQ;
                end else if (handshake) begin
                    count_next = count + 1'b1;
                end
            end
            POLL_REQ:  state_next = POLL_WAIT;
            POLL_WAIT: begin
                if (readdata[0]) begin
                    state_next = RD_REQ;
                end else if (poll_timeout) begin
                    state_next = IDLE;
                end else begin
                    state_next = POLL_REQ;
                end
            end
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus strobes are launched from next_state so they sit in the REQ cycle with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address      <= '0;
            read         <= 1'b0;
            write        <= 1'b0;
            writedata    <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            read         <= 1'b0;
            write        <= 1'b0;
            result_valid <= 1'b0;
            if (handshake) begin
                write     <= 1'b1;
                writedata <= in_data;
                address   <= ((state == LOAD_W) ? WEIGHT_BASE : IMAGE_BASE) + 8'(count);
            end
            if (state_next == POLL_REQ) begin
                read    <= 1'b1;
                address <= STATUS_ADDR;
            end
            if (state_next == RD_REQ) begin
                read    <= 1'b1;
                address <= RESULT_ADDR;
            end
            if (state == RD_WAIT) begin
                result       <= readdata;
                result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/nn_acc_host_master.md
# nn_acc_host_master

Avalon-MM-style master that drives the single MAC neural-network accelerator slave through one complete inference. On `start` it streams 96 weight words and then 96 image words from an upstream valid/ready source into the slave's weight and image windows. It then polls the slave's result-ready status register, reads the 32-bit floating-point result, and presents it upstream with a one-cycle valid pulse. It sits between a DMA/stream source and the accelerator slave port.

## Interface
Parameters:
- `WEIGHT_COUNT`, 96: weight words written per inference.
- `IMAGE_COUNT`, 96: image words written per inference.
- `WEIGHT_BASE`, 8'h01: first weight address; incremented per word.
- `IMAGE_BASE`, 8'h61: first image address; incremented per word.
- `RESULT_ADDR`, 8'hC1: result register address.
- `STATUS_ADDR`, 8'hD9: status register address; bit 0 = result ready.
- `POLL_LIMIT`, 1024: maximum status polls before timeout (only with `NN_HOST_MASTER_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin an inference; ignored while `busy`.
- `busy`  out  1  high from the cycle after accepted `start` until return to IDLE.
- `in_data`  in  32  weight/image word from upstream.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  high in LOAD_W/LOAD_I; transfer on `in_valid && in_ready`.
- `result`  out  32  captured result word, held until next capture.
- `result_valid`  out  1  one-cycle pulse when `result` updates.
- `error`  out  1  one-cycle pulse on poll timeout.
- `address`  out  8  slave address.
- `read`  out  1  slave read strobe.
- `write`  out  1  slave write strobe.
- `writedata`  out  32  slave write data.
- `readdata`  in  32  slave read data; valid exactly 1 cycle after `read`, no waitrequest.

## Operation
- States: IDLE, LOAD_W, LOAD_I, POLL_REQ, POLL_WAIT, RD_REQ, RD_WAIT.
- IDLE: on `start`, go to LOAD_W; clear word counter.
- LOAD_W: each handshake registers `write`=1, `address`=`WEIGHT_BASE`+count, `writedata`=`in_data` for the next cycle. Increment count. After `WEIGHT_COUNT` handshakes, clear count and go to LOAD_I. Weights always precede image words because the slave starts computing when its image buffer goes non-empty.
- LOAD_I: same behaviour with `IMAGE_BASE`. After `IMAGE_COUNT` handshakes, go to POLL_REQ.
- POLL_REQ: drive `read`=1, `address`=`STATUS_ADDR` for one cycle, then go to POLL_WAIT.
- POLL_WAIT: sample `readdata[0]`. If 1, go to RD_REQ. If 0, go to POLL_REQ, or raise a timeout when enabled (see Configuration).
- RD_REQ: drive `read`=1, `address`=`RESULT_ADDR` for one cycle, then go to RD_WAIT.
- RD_WAIT: `result` <= `readdata`; pulse `result_valid`; go to IDLE. This read clears the slave's ready flag.
- `in_valid` low during a load: `write` stays 0 and the count holds. Gaps are permitted anywhere in the stream.
- `read` and `write` are never high in the same cycle. All slave outputs are registered.
- Count width is $clog2(max(WEIGHT_COUNT, IMAGE_COUNT)+1). The count never wraps; it stops exactly at the limit.
- Reset (any state, including mid-load): state=IDLE; `busy`, `in_ready`, `read`, `write`, `result_valid`, `error` = 0; `address`=0, `writedata`=0, `result`=0, count=0.

## Timing
- `start` at edge N: `busy` and `in_ready` are high from cycle N+1.
- Handshake at edge K: `write` pulse is in cycle K+1.
- With `in_valid` held high: one write per cycle, and 192 write cycles back-to-back. `in_ready` drops the cycle after the 192nd handshake.
- First status read: the cycle after the final image write pulse.
- Each poll takes 2 cycles.
- Result: `result_valid` is asserted 2 cycles after the ready status is sampled. `busy` deasserts in the same cycle as `result_valid`.
- `start` during `busy`, including in the same cycle that `result_valid` is pulsed: ignored, not queued.

## Configuration
- `NN_HOST_MASTER_TIMEOUT_EN` defined:
  - A poll counter increments on every status read that returns 0.
  - When it reaches `POLL_LIMIT`, pulse `error` for one cycle, go to IDLE and deassert `busy`. No result read is issued.
  - The counter clears on `start`.
- Not defined: polling continues indefinitely; `error` is tied to 0 and no counter exists.

## Test plan
- Reset mid-LOAD_W (after 40 words) -> all outputs 0 next cycle, state IDLE. A new `start` then writes from address 8'h01.
- `start`, 192 words streamed back-to-back (weights 1.0f=32'h3F800000, image 2.0f=32'h40000000); slave model sets ready after 100 cycles and returns 32'h43400000 -> addresses 8'h01..8'h60, then 8'h61..8'hC0, one write each; polls at 8'hD9; one read at 8'hC1; `result`=32'h43400000 with a one-cycle `result_valid`.
- `in_valid` toggled every other cycle -> exactly 192 write pulses, contiguous addresses, no duplicates or skips.
- `start` pulsed during LOAD_I and in the `result_valid` cycle -> ignored; exactly one inference runs.
- Status reads 0 five times and then 1 -> exactly 6 reads of 8'hD9 at 2-cycle spacing, followed by one read of 8'hC1.
- With `NN_HOST_MASTER_TIMEOUT_EN` defined and `POLL_LIMIT`=4, status never set -> 4 polls, `error` pulsed once, no read of 8'hC1, `busy` low.
